// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults and sizing helper for the FIFO family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DATA_WIDTH = 4;
    localparam int FIFO_DEPTH = 8;

    // Index width of the storage array; pointers carry one extra wrap bit.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module      : fifo_mem
// Description : Simple dual-port register array, synchronous write port and
//               registered read port. Storage itself is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] storage [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset so rd_data comes up as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= storage[rd_addr];
        end
    end

endmodule : fifo_mem

`default_nettype wire

// File: rtl/sync_fifo_flags.sv
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock FIFO with registered read data and registered
//               full / afull / aempty / empty flags. Defining FIFO_ERR_FLAG_EN
//               adds sticky overflow / underflow outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_flags #(
    parameter int DATA_WIDTH  = fifo_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH  = fifo_pkg::FIFO_DEPTH,
    parameter int FIFO_AFULL  = FIFO_DEPTH - 1,
    parameter int FIFO_AEMPTY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  afull,
    output logic                  aempty,
    output logic                  empty
`ifdef FIFO_ERR_FLAG_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    import fifo_pkg::*;

    localparam int AW = addr_width(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] AFULL_LVL  = PW'(FIFO_AFULL);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(FIFO_AEMPTY);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] count_next;
    logic          wr_accept;
    logic          rd_accept;
    logic          full_next;
    logic          empty_next;

    // Each side is judged against the flags as they stood before the edge.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (wr_accept) begin
            wr_ptr_next = wr_ptr + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr + PTR_ONE;
        end
    end

    assign count_next = wr_ptr_next - rd_ptr_next;
    assign empty_next = (wr_ptr_next == rd_ptr_next);
    assign full_next  = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                        (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            afull  <= 1'b0;
            aempty <= 1'b1;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            full   <= full_next;
            afull  <= (count_next >= AFULL_LVL);
            aempty <= (count_next <= AEMPTY_LVL);
            empty  <= empty_next;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

`ifdef FIFO_ERR_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule : sync_fifo_flags

`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
// ============================================================================
// Module      : tb_sync_fifo_flags
// Description : Self-checking bench for sync_fifo_flags (vector table plus
//               queue-based reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_flags;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'd0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_data;
    logic       full, afull, aempty, empty;
`ifdef FIFO_ERR_FLAG_EN
    logic       overflow, underflow;
`endif

    sync_fifo_flags dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (full),
        .afull   (afull),
        .aempty  (aempty),
        .empty   (empty)
`ifdef FIFO_ERR_FLAG_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [3:0] wd;
        logic [3:0] rdat;
        logic       f;
        logic       af;
        logic       ae;
        logic       e;
    } vec_t;

    vec_t vecs [20];

    logic [3:0] mq [$];
    logic [3:0] exp_q [$];
    logic [3:0] last_rd = 4'd0;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model decides acceptance from pre-edge occupancy, then compare.
    task automatic step(input logic w, input logic r, input logic [3:0] d);
        logic wacc, racc;
        wacc = w && (mq.size() < DEPTH);
        racc = r && (mq.size() > 0);
        wr_en = w; rd_en = r; wr_data = d;
        if (racc) exp_q.push_back(mq.pop_front());
        if (wacc) mq.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        if (racc) last_rd = exp_q.pop_front();
        chk("rd_data", rd_data, last_rd);
        chk("full",   full,   mq.size() == DEPTH);
        chk("afull",  afull,  mq.size() >= DEPTH - 1);
        chk("aempty", aempty, mq.size() <= 1);
        chk("empty",  empty,  mq.size() == 0);
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [3:0] wd,
                                input logic [3:0] rdat, input logic f, input logic af,
                                input logic ae, input logic e);
        vec_t v;
        v.wr = wr; v.rd = rd; v.wd = wd; v.rdat = rdat;
        v.f = f; v.af = af; v.ae = ae; v.e = e;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        last_rd = 4'd0;
    endtask

    initial begin
        // Fill with overflow, then drain with underflow; flags are post-edge.
        vecs[0]  = mk(1, 0, 4'd13, 4'd0, 0, 0, 1, 0);
        vecs[1]  = mk(1, 0, 4'd14, 4'd0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 4'd15, 4'd0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 4'd0,  4'd0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 4'd1,  4'd0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 4'd2,  4'd0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 4'd3,  4'd0, 0, 1, 0, 0);
        vecs[7]  = mk(1, 0, 4'd4,  4'd0, 1, 1, 0, 0);
        vecs[8]  = mk(1, 0, 4'd5,  4'd0, 1, 1, 0, 0);
        vecs[9]  = mk(1, 0, 4'd6,  4'd0, 1, 1, 0, 0);
        vecs[10] = mk(0, 1, 4'd0, 4'd13, 0, 1, 0, 0);
        vecs[11] = mk(0, 1, 4'd0, 4'd14, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 4'd0, 4'd15, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 4'd0, 4'd0,  0, 0, 0, 0);
        vecs[14] = mk(0, 1, 4'd0, 4'd1,  0, 0, 0, 0);
        vecs[15] = mk(0, 1, 4'd0, 4'd2,  0, 0, 0, 0);
        vecs[16] = mk(0, 1, 4'd0, 4'd3,  0, 0, 1, 0);
        vecs[17] = mk(0, 1, 4'd0, 4'd4,  0, 0, 1, 1);
        vecs[18] = mk(0, 1, 4'd0, 4'd4,  0, 0, 1, 1);
        vecs[19] = mk(0, 1, 4'd0, 4'd4,  0, 0, 1, 1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_empty",  empty,   1);
        chk("rst_aempty", aempty,  1);
        chk("rst_full",   full,    0);
        chk("rst_afull",  afull,   0);
        chk("rst_rdata",  rd_data, 0);

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].wd);
            chk($sformatf("tbl%0d_rdata", i),  rd_data, vecs[i].rdat);
            chk($sformatf("tbl%0d_full", i),   full,    vecs[i].f);
            chk($sformatf("tbl%0d_afull", i),  afull,   vecs[i].af);
            chk($sformatf("tbl%0d_aempty", i), aempty,  vecs[i].ae);
            chk($sformatf("tbl%0d_empty", i),  empty,   vecs[i].e);
        end
`ifdef FIFO_ERR_FLAG_EN
        chk("overflow_sticky",  overflow,  1);
        chk("underflow_sticky", underflow, 1);
`endif

        // Simultaneous access at occupancy 4: occupancy and flags stay put.
        for (int i = 0; i < 4; i++) step(1, 0, 4'(i + 1));
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 4'(i + 8));
            chk("simul_afull",  afull,  0);
            chk("simul_aempty", aempty, 0);
        end
        // Top up to full, then read+write together: only the read proceeds.
        while (mq.size() < DEPTH) step(1, 0, 4'($urandom_range(0, 15)));
        chk("pre_full", full, 1);
        step(1, 1, 4'd9);
        chk("full_rw_full",  full,  0);
        chk("full_rw_afull", afull, 1);
        chk("full_rw_occ",   mq.size(), 7);
        while (mq.size() > 0) step(0, 1, 4'd0);

        // Three complete fill/drain passes exercise the pointer wrap bit.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < DEPTH; i++) step(1, 0, 4'($urandom_range(0, 15)));
            chk("wrap_full", full, 1);
            for (int i = 0; i < DEPTH; i++) step(0, 1, 4'd0);
            chk("wrap_empty", empty, 1);
        end

        // Asynchronous reset with occupancy 5.
        for (int i = 0; i < 5; i++) step(1, 0, 4'(i + 3));
        step(0, 1, 4'd0);
        step(1, 0, 4'd7);
        #2 rst = 1'b1;
        #1;
        chk("midrst_empty",  empty,   1);
        chk("midrst_aempty", aempty,  1);
        chk("midrst_full",   full,    0);
        chk("midrst_rdata",  rd_data, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
`ifdef FIFO_ERR_FLAG_EN
        chk("overflow_clr",  overflow,  0);
        chk("underflow_clr", underflow, 0);
`endif
        step(1, 0, 4'hA);
        step(0, 1, 4'd0);
        chk("post_rst_read", rd_data, 4'hA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_sync_fifo_flags

`default_nettype wire
